// File: rtl/adau1761_init_sequencer_if.sv
// Command bus from the init sequencer to the ADAU1761 SPI configurator.
// The sequencer drives every signal; the configurator only listens.
interface adau1761_init_sequencer_if;
    logic [15:0] address;
    logic [7:0]  write_value;
    logic        write;
    logic        init;
    logic        read;

    modport master (
        output address,
        output write_value,
        output write,
        output init,
        output read
    );

    modport slave (
        input address,
        input write_value,
        input write,
        input init,
        input read
    );
endinterface

// File: rtl/adau1761_init_sequencer.sv
// Walks a (address, value) register table and feeds one SPI write per entry
// to the ADAU1761 configurator, with a reserved address for timed waits.
module adau1761_init_sequencer #(
    parameter int          NUM_ENTRIES    = 16,
    parameter int          GAP_CYCLES     = 40,
    parameter int          STARTUP_CYCLES = 128,
    parameter int          INIT_CYCLES    = 128,
    parameter int          DELAY_UNIT     = 1024,
    parameter logic [15:0] DELAY_ADDR     = 16'hFFFF,
    parameter bit          AUTO_START     = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic [7:0]  rom_addr,
    input  logic [23:0] rom_data,
    adau1761_init_sequencer_if.master cfg,
    output logic        busy,
    output logic        done,
    output logic        fault
);

    typedef enum logic [3:0] {
        STARTUP, IDLE, INIT, INIT_WAIT, FETCH,
        LATCH, ISSUE, GAP, DELAY, DONE
    } state_t;

    localparam bit BAD_SIZE = (NUM_ENTRIES < 1) || (NUM_ENTRIES > 256);
    localparam logic [7:0]  LAST_IDX     = BAD_SIZE ? 8'd0 : 8'(NUM_ENTRIES - 1);
    localparam logic [31:0] STARTUP_LAST = 32'(STARTUP_CYCLES - 1);
    localparam logic [31:0] INIT_LAST    = 32'(INIT_CYCLES - 1);
    localparam logic [31:0] GAP_LAST     = 32'(GAP_CYCLES - 1);
    localparam logic [31:0] UNIT         = 32'(DELAY_UNIT);

    state_t      state, state_n;
    logic [31:0] counter, counter_n;
    logic [7:0]  index, index_n;
    logic [15:0] addr_q, addr_n;
    logic [7:0]  value_q, value_n;
    logic        fault_q, fault_n;
    logic        adv, walk;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= STARTUP;
            counter <= '0;
            index   <= '0;
            addr_q  <= '0;
            value_q <= '0;
            fault_q <= 1'b0;
        end else begin
            state   <= state_n;
            counter <= counter_n;
            index   <= index_n;
            addr_q  <= addr_n;
            value_q <= value_n;
            fault_q <= fault_n;
        end
    end

    always_comb begin
        state_n   = state;
        counter_n = counter;
        index_n   = index;
        addr_n    = addr_q;
        value_n   = value_q;
        fault_n   = fault_q;
        adv       = 1'b0;
        walk      = 1'b0;
        unique case (state)
            STARTUP: begin
                if (counter >= STARTUP_LAST) begin
                    counter_n = '0;
                    if (AUTO_START) walk = 1'b1;
                    else            state_n = IDLE;
                end else begin
                    counter_n = counter + 32'd1;
                end
            end
            IDLE, DONE: begin
                if (start) begin
                    state_n = INIT;
                    index_n = '0;
                end
            end
            INIT: begin
                state_n   = INIT_WAIT;
                counter_n = 32'd1;
            end
            INIT_WAIT: begin
                if (counter >= INIT_LAST) begin
                    counter_n = '0;
                    walk      = 1'b1;
                end else begin
                    counter_n = counter + 32'd1;
                end
            end
            FETCH: state_n = LATCH;
            LATCH: begin
                if (rom_data[23:8] == DELAY_ADDR) begin
                    if (rom_data[7:0] == 8'd0) begin
                        adv = 1'b1;
                    end else begin
                        counter_n = {24'd0, rom_data[7:0]} * UNIT;
                        state_n   = DELAY;
                    end
                end else begin
                    addr_n  = rom_data[23:8];
                    value_n = rom_data[7:0];
                    state_n = ISSUE;
                end
            end
            // the ISSUE cycle counts as the first cycle of the gap
            ISSUE: begin
                counter_n = 32'd1;
                state_n   = GAP;
            end
            GAP: begin
                if (counter >= GAP_LAST) adv = 1'b1;
                else                     counter_n = counter + 32'd1;
            end
            DELAY: begin
                if (counter <= 32'd1) adv = 1'b1;
                else                  counter_n = counter - 32'd1;
            end
            default: state_n = STARTUP;
        endcase

        if (walk) begin
            index_n = '0;
            fault_n = fault_q | BAD_SIZE;
            state_n = BAD_SIZE ? DONE : FETCH;
        end

        if (adv) begin
            counter_n = '0;
            if (index == LAST_IDX) begin
                state_n = DONE;
            end else begin
                index_n = index + 8'd1;
                state_n = FETCH;
            end
        end
    end

    assign rom_addr        = index;
    assign cfg.address     = addr_q;
    assign cfg.write_value = value_q;
    assign cfg.write       = (state == ISSUE);
    assign cfg.init        = (state == INIT);
    assign cfg.read        = 1'b0;
    assign busy            = (state != IDLE) && (state != DONE);
    assign done            = (state == DONE);
    assign fault           = fault_q;

endmodule

// File: tb/tb_adau1761_init_sequencer.sv
// Directed bench: table walk timing, delay entry, restart, reset mid-walk,
// ignored starts and the bad-table-size fault.
module tb_adau1761_init_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  rom_addr;
    logic [23:0] rom_data;
    logic        busy, done, fault;

    logic        fstart;
    logic [7:0]  from_addr;
    logic [23:0] from_data;
    logic        fbusy, fdone, ffault;

    logic [23:0] rom [0:255];

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int wr_seen = 0;
    int in_seen = 0;
    int both_seen = 0;
    int fw_seen = 0;
    int fi_seen = 0;
    int t0;

    adau1761_init_sequencer_if bus ();
    adau1761_init_sequencer_if fbus ();

    always #5 clk = ~clk;

    always_ff @(posedge clk) rom_data <= rom[rom_addr];

    adau1761_init_sequencer #(
        .NUM_ENTRIES(5), .GAP_CYCLES(40), .STARTUP_CYCLES(128),
        .INIT_CYCLES(128), .DELAY_UNIT(16), .DELAY_ADDR(16'hFFFF),
        .AUTO_START(1'b1)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .rom_addr(rom_addr), .rom_data(rom_data), .cfg(bus),
        .busy(busy), .done(done), .fault(fault)
    );

    adau1761_init_sequencer #(
        .NUM_ENTRIES(0), .GAP_CYCLES(40), .STARTUP_CYCLES(128),
        .INIT_CYCLES(128), .DELAY_UNIT(16), .DELAY_ADDR(16'hFFFF),
        .AUTO_START(1'b1)
    ) dutf (
        .clk(clk), .reset(reset), .start(fstart),
        .rom_addr(from_addr), .rom_data(from_data), .cfg(fbus),
        .busy(fbusy), .done(fdone), .fault(ffault)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        if (bus.write) wr_seen++;
        if (bus.init) in_seen++;
        if (bus.write && bus.init) both_seen++;
        if (fbus.write) fw_seen++;
        if (fbus.init) fi_seen++;
    endtask

    task automatic expect_write(input string tag, input int exp_cyc,
                                input logic [15:0] a, input logic [7:0] v);
        int at;
        at = -1;
        for (int i = 0; i < 400; i++) begin
            step();
            if (bus.write) begin
                at = cyc;
                break;
            end
        end
        check({tag, "_cyc"}, 32'(at), 32'(exp_cyc));
        check({tag, "_addr"}, 32'(bus.address), 32'(a));
        check({tag, "_val"}, 32'(bus.write_value), 32'(v));
        check({tag, "_busy"}, 32'(busy), 32'd1);
        step();
        check({tag, "_width"}, 32'(bus.write), 32'd0);
    endtask

    task automatic expect_done(input string tag, input int exp_cyc);
        int at;
        at = -1;
        for (int i = 0; i < 400; i++) begin
            step();
            if (done) begin
                at = cyc;
                break;
            end
        end
        check({tag, "_cyc"}, 32'(at), 32'(exp_cyc));
        check({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 24'h000000;
        rom[0] = 24'h4000_01;
        rom[1] = 24'h4002_00;
        rom[2] = 24'h4015_01;
        rom[3] = 24'hFFFF_03;
        rom[4] = 24'h4017_55;
        from_data = 24'h000000;
        reset  = 1'b1;
        start  = 1'b0;
        fstart = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_fault", 32'(fault), 32'd0);
        check("rst_strobes", 32'({bus.write, bus.init, bus.read}), 32'd0);
        check("rst_addr", 32'(bus.address), 32'd0);
        check("rst_val", 32'(bus.write_value), 32'd0);
        check("rst_rom_addr", 32'(rom_addr), 32'd0);
        check("rst_ffault", 32'(ffault), 32'd0);

        reset = 1'b0;
        cyc = 1;
        while (cyc < 10) step();
        start = 1'b1;
        step();
        start = 1'b0;

        expect_write("w0", 131, 16'h4000, 8'h01);
        start = 1'b1;
        step();
        start = 1'b0;
        while (cyc < 172) step();
        check("w0_hold_addr", 32'(bus.address), 32'h4000);
        expect_write("w1", 173, 16'h4002, 8'h00);
        expect_write("w2", 215, 16'h4015, 8'h01);
        expect_write("w4_after_delay", 307, 16'h4017, 8'h55);
        expect_done("done1", 347);
        check("walk1_writes", 32'(wr_seen), 32'd4);
        check("walk1_no_init", 32'(in_seen), 32'd0);
        check("f_done", 32'(fdone), 32'd1);
        check("f_fault", 32'(ffault), 32'd1);
        check("f_busy", 32'(fbusy), 32'd0);
        check("f_no_pulses", 32'(fw_seen + fi_seen), 32'd0);

        while (cyc < 350) step();
        start  = 1'b1;
        fstart = 1'b1;
        step();
        start  = 1'b0;
        fstart = 1'b0;
        t0 = cyc;
        check("restart_init", 32'(bus.init), 32'd1);
        check("restart_busy", 32'(busy), 32'd1);
        check("restart_done_clr", 32'(done), 32'd0);
        check("restart_no_write", 32'(bus.write), 32'd0);
        step();
        check("restart_init_width", 32'(bus.init), 32'd0);
        expect_write("rw0", t0 + 130, 16'h4000, 8'h01);
        check("f_fault_after_start", 32'(ffault), 32'd1);
        check("f_done_after_start", 32'(fdone), 32'd1);
        check("f_no_write_after_start", 32'(fw_seen), 32'd0);
        expect_write("rw1", t0 + 172, 16'h4002, 8'h00);

        repeat (3) step();
        reset = 1'b1;
        step();
        check("midrst_write", 32'(bus.write), 32'd0);
        check("midrst_busy", 32'(busy), 32'd1);
        check("midrst_index", 32'(rom_addr), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_ffault_clr", 32'(ffault), 32'd0);
        reset = 1'b0;
        cyc = 1;
        wr_seen = 0;
        expect_write("x0", 131, 16'h4000, 8'h01);
        expect_write("x1", 173, 16'h4002, 8'h00);
        expect_write("x2", 215, 16'h4015, 8'h01);
        expect_write("x4", 307, 16'h4017, 8'h55);
        expect_done("done3", 347);
        check("walk3_writes", 32'(wr_seen), 32'd4);
        check("never_both", 32'(both_seen), 32'd0);
        check("init_total", 32'(in_seen), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/adau1761_init_sequencer.md
Name: adau1761_init_sequencer

Overview:
- Upstream command source for the ADAU1761 SPI configurator. Drives its address, write_value, write and init inputs.
- Walks an external register table of (16-bit address, 8-bit value) entries and issues one write per entry. Timed gaps let each 32-bit SPI frame finish.
- A reserved table address inserts a programmable wait, such as for PLL lock. Reports busy/done and a fault on a malformed table size.

Parameters:
- NUM_ENTRIES, 16, number of table entries walked (1..256)
- GAP_CYCLES, 40, cycles from a write pulse to the next command (must be at least 34: 32 SPI bits plus 2)
- STARTUP_CYCLES, 128, wait after reset before the first action (covers the configurator's self-init)
- INIT_CYCLES, 128, wait after an init pulse before the table walk starts
- DELAY_UNIT, 1024, cycles per count of a delay entry
- DELAY_ADDR, 16'hFFFF, table address that marks a delay entry (never sent over SPI)
- AUTO_START, 1, 1 = walk the table automatically after STARTUP_CYCLES

Ports:
- clk  in  1  system clock; the same clock as the configurator
- reset  in  1  synchronous, active-high reset
- start  in  1  single-cycle request: re-init the codec and re-walk the table
- rom_addr  out  8  table index presented to the external ROM
- rom_data  in  24  {address[15:0], value[7:0]}, valid exactly 1 cycle after rom_addr changes
- address  out  16  to configurator address
- write_value  out  8  to configurator write_value
- write  out  1  single-cycle write strobe to the configurator
- init  out  1  single-cycle init strobe to the configurator
- read  out  1  tied 0 (reads are not issued by this block)
- busy  out  1  high in every state except IDLE and DONE
- done  out  1  high in DONE until start or reset
- fault  out  1  sticky; set when NUM_ENTRIES is 0 or greater than 256 at the start of a walk

Behaviour:
- Reset (synchronous, active-high):
  - state = STARTUP, counter = 0, index = 0.
  - Outputs: rom_addr = 0, address = 0, write_value = 0, write = 0, init = 0, busy = 1, done = 0, fault = 0.
  - A reset mid-frame abandons the walk immediately; write and init drop the next cycle.
- States: STARTUP, IDLE, INIT, INIT_WAIT, FETCH, LATCH, ISSUE, GAP, DELAY, DONE.
- STARTUP: count STARTUP_CYCLES. Then go to FETCH with index 0 if AUTO_START = 1, else to IDLE (busy = 0).
- IDLE / DONE: start -> INIT; index = 0; done cleared.
- INIT: init = 1 for exactly one cycle -> INIT_WAIT.
- INIT_WAIT: count INIT_CYCLES -> FETCH.
- FETCH: rom_addr = index -> LATCH.
- LATCH: capture rom_data.
  - Entry address == DELAY_ADDR: load counter = value*DELAY_UNIT -> DELAY. A value of 0 means no delay: go straight to advance.
  - Otherwise: address and write_value take the entry -> ISSUE.
- ISSUE: write = 1 for exactly one cycle. address and write_value must already be stable that cycle and stay stable until the next ISSUE -> GAP.
- GAP: count GAP_CYCLES (counted from the ISSUE cycle) -> advance.
- DELAY: count down to 0 -> advance.
- Advance:
  - index == NUM_ENTRIES-1 -> DONE (done = 1, busy = 0).
  - Otherwise index + 1 -> FETCH.
- Cadence: writes on consecutive entries are exactly GAP_CYCLES+2 cycles apart (ISSUE to ISSUE).
- write and init are never high in the same cycle. Neither is ever high for more than one cycle.
- start is ignored while busy, including during STARTUP.
- Counters: 32 bits wide. value*DELAY_UNIT must fit without overflow (max 255*DELAY_UNIT).
- fault:
  - Checked on entering FETCH for index 0.
  - If set: go to DONE with no writes; done = 1 and fault = 1.
  - fault clears only on reset.
- read is held at 0 in all states.

Test Plan:
- Reset, AUTO_START = 1, 3-entry table {0x4000:0x01, 0x4002:0x00, 0x4015:0x01}, GAP_CYCLES = 40:
  - First write pulse at cycle 131 after reset release.
  - Following writes at 173 and 215, with address/write_value matching each entry.
  - done rises after the last gap; init is never pulsed.
- Delay entry 0xFFFF:0x03 between two writes, DELAY_UNIT = 16: the second write is exactly 2+48+2 cycles after the first gap ends, and no write is issued for the delay entry.
- In DONE, pulse start:
  - init is high for exactly 1 cycle, and busy rises the same cycle.
  - The first write comes INIT_CYCLES+2 cycles after the init pulse; done clears on start.
- start pulsed during GAP and during STARTUP -> ignored; the write sequence and timing are identical to the no-start case.
- Assert reset mid-walk during entry 1's GAP -> the next cycle shows write = 0, busy = 1, index restarts at 0, and the full table is re-issued after STARTUP_CYCLES.
- NUM_ENTRIES = 0 -> no write or init pulse; done = 1 and fault = 1 after STARTUP; fault is still 1 after a start pulse; it clears only on reset.
